poly_mul_ctrl: RTL and testbench

Sequencer for the poly_mul butterfly/multiply datapath on 256-coefficient Dilithium polynomials. Accepts one operation command (NTT, INTT, pointwise MULT, ADD), drives sel/ntt_l/tf_address into poly_mul, and issues coefficient-RAM read and write strobes. Read strobes run linearly per stage; write strobes are delayed by the pipeline latency. The external bank/address remapper consumes rd_addr/rd_stage.

---
 rtl/poly_mul_pkg.sv | 35 +++
 rtl/poly_mul_delay.sv | 33 +++
 rtl/poly_mul_tf_agen.sv | 35 +++
 rtl/poly_mul_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_poly_mul_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/poly_mul_pkg.sv
// Shared encodings and geometry for the poly_mul sequencer and its twiddle address generator.
package poly_mul_pkg;

    localparam logic [2:0] MODE_NTT  = 3'b001;
    localparam logic [2:0] MODE_INTT = 3'b100;
    localparam logic [2:0] MODE_MUL  = 3'b010;
    localparam logic [2:0] MODE_ADD  = 3'b110;

    localparam logic [1:0] NTT_L_LOW = 2'd0;
    localparam logic [1:0] NTT_L_L6  = 2'd1;
    localparam logic [1:0] NTT_L_L7  = 2'd2;

    localparam int CYC_BFLY   = 32;
    localparam int CYC_PW     = 64;
    localparam int NUM_STAGES = 8;

    localparam logic [7:0] TF_BASE_LOW  = 8'd0;
    localparam logic [7:0] TF_BASE_HIGH = 8'd63;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_FIN
    } state_t;

    function automatic logic mode_is_bfly(input logic [2:0] m);
        return (m == MODE_NTT) || (m == MODE_INTT);
    endfunction

    function automatic logic mode_legal(input logic [2:0] m);
        return mode_is_bfly(m) || (m == MODE_MUL) || (m == MODE_ADD);
    endfunction

endpackage

// File: rtl/poly_mul_delay.sv
// Clearable shift register exposing every tap; tap k carries the input delayed k+1 cycles.
module poly_mul_delay #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       d_i,
    output logic [DEPTH*WIDTH-1:0] taps_o
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tap
            assign taps_o[gi*WIDTH +: WIDTH] = pipe_q[gi];
        end
    endgenerate

endmodule

// File: rtl/poly_mul_tf_agen.sv
// Combinational twiddle ROM address and layer-group code from (mode, stage, issue index).
module poly_mul_tf_agen
    import poly_mul_pkg::*;
(
    input  logic [2:0] mode_i,
    input  logic [2:0] stage_i,
    input  logic [5:0] addr_i,
    output logic [1:0] ntt_l_o,
    output logic [7:0] tf_address_o
);

    logic [7:0] c_ext;
    assign c_ext = {2'b00, addr_i};

    always_comb begin
        ntt_l_o      = NTT_L_LOW;
        tf_address_o = '0;
        if (mode_is_bfly(mode_i)) begin
            if (stage_i == 3'd7) begin
                ntt_l_o      = NTT_L_L7;
                tf_address_o = TF_BASE_HIGH + c_ext;
            end else if (stage_i == 3'd6) begin
                ntt_l_o      = NTT_L_L6;
                tf_address_o = TF_BASE_HIGH + c_ext;
            end else begin
                // Low layers share one twiddle across 2^(5-s) consecutive issue slots.
                tf_address_o = TF_BASE_LOW + ((8'd1 << stage_i) - 8'd1)
                             + (c_ext >> (3'd5 - stage_i));
            end
        end else if ((mode_i == MODE_MUL) || (mode_i == MODE_ADD)) begin
            ntt_l_o = NTT_L_L7;
        end
    end

endmodule

// File: rtl/poly_mul_ctrl.sv
// Stage/issue sequencer for poly_mul with latency-matched write strobes.
// Optional busy-cycle counter output perf_cycles under macro POLY_MUL_CTRL_PERF_EN.
module poly_mul_ctrl
    import poly_mul_pkg::*;
#(
    parameter int LAT_NTT  = 5,
    parameter int LAT_INTT = 6,
    parameter int LAT_MUL  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  mode,
    output logic        busy,
    output logic        done,
    output logic [2:0]  sel,
    output logic [1:0]  ntt_l,
    output logic [7:0]  tf_address,
    output logic        rd_en,
    output logic [5:0]  rd_addr,
    output logic [2:0]  rd_stage,
    output logic        wr_en,
    output logic [5:0]  wr_addr,
    output logic [2:0]  wr_stage
`ifdef POLY_MUL_CTRL_PERF_EN
    ,
    output logic [15:0] perf_cycles
`endif
);

    localparam int LAT_MAX0 = (LAT_NTT > LAT_INTT) ? LAT_NTT : LAT_INTT;
    localparam int LAT_MAX  = (LAT_MAX0 > LAT_MUL) ? LAT_MAX0 : LAT_MUL;
    localparam int IW       = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
    localparam int DW       = 10;

    state_t     state_q, state_d;
    logic [2:0] mode_q,  mode_d;
    logic [5:0] addr_q,  addr_d;
    logic [2:0] stage_q, stage_d;
    logic [3:0] drain_q, drain_d;

    logic       accept;
    logic [3:0] lat_cur;
    logic [5:0] cyc_last;
    logic       last_stage;

    assign accept     = (state_q == ST_IDLE) && start && mode_legal(mode);
    assign cyc_last   = mode_is_bfly(mode_q) ? 6'(CYC_BFLY - 1) : 6'(CYC_PW - 1);
    assign last_stage = (mode_q == MODE_NTT) ? (stage_q == 3'(NUM_STAGES - 1))
                                             : (stage_q == 3'd0);

    always_comb begin
        if (mode_q == MODE_NTT) begin
            lat_cur = 4'(LAT_NTT);
        end else if (mode_q == MODE_INTT) begin
            lat_cur = 4'(LAT_INTT);
        end else begin
            lat_cur = 4'(LAT_MUL);
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        stage_d = stage_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_RUN;
                    mode_d  = mode;
                    addr_d  = '0;
                    drain_d = '0;
                    stage_d = (mode == MODE_INTT) ? 3'(NUM_STAGES - 1) : 3'd0;
                end
            end
            ST_RUN: begin
                if (addr_q == cyc_last) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    addr_d = addr_q + 6'd1;
                end
            end
            ST_DRAIN: begin
                // Reads pause for one full pipeline latency so the next stage sees written data.
                if (drain_q == lat_cur - 4'd1) begin
                    if (last_stage) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_RUN;
                        addr_d  = '0;
                        stage_d = (mode_q == MODE_INTT) ? stage_q - 3'd1 : stage_q + 3'd1;
                    end
                end else begin
                    drain_d = drain_q + 4'd1;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                addr_d  = '0;
                stage_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            addr_q  <= '0;
            stage_q <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            stage_q <= stage_d;
            drain_q <= drain_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_FIN);
    assign sel      = busy ? mode_q : 3'b000;
    assign rd_en    = (state_q == ST_RUN);
    assign rd_addr  = addr_q;
    assign rd_stage = stage_q;

    poly_mul_tf_agen u_tf_agen (
        .mode_i       (sel),
        .stage_i      (stage_q),
        .addr_i       (addr_q),
        .ntt_l_o      (ntt_l),
        .tf_address_o (tf_address)
    );

    logic [LAT_MAX*DW-1:0] taps_flat;
    logic [DW-1:0]         tap [LAT_MAX];
    logic [IW-1:0]         lat_idx;
    logic [DW-1:0]         wr_word;

    poly_mul_delay #(
        .WIDTH (DW),
        .DEPTH (LAT_MAX)
    ) u_wr_delay (
        .clk    (clk),
        .rst    (rst),
        .d_i    ({rd_en, rd_addr, rd_stage}),
        .taps_o (taps_flat)
    );

    generate
        for (genvar gi = 0; gi < LAT_MAX; gi++) begin : g_tap
            assign tap[gi] = taps_flat[gi*DW +: DW];
        end
    endgenerate

    assign lat_idx = IW'(lat_cur - 4'd1);
    assign wr_word = tap[lat_idx];
    assign {wr_en, wr_addr, wr_stage} = wr_word;

`ifdef POLY_MUL_CTRL_PERF_EN
    logic [15:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (accept) begin
            perf_d = 16'd1;
        end else if ((state_q == ST_RUN) || (state_q == ST_DRAIN)) begin
            perf_d = perf_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_poly_mul_ctrl.sv
// Directed bench for poly_mul_ctrl: NTT, MULT, INTT, ignored starts, async reset, ADD.
module tb_poly_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  mode;
    logic        busy, done, rd_en, wr_en;
    logic [2:0]  sel, rd_stage, wr_stage;
    logic [1:0]  ntt_l;
    logic [7:0]  tf_address;
    logic [5:0]  rd_addr, wr_addr;
`ifdef POLY_MUL_CTRL_PERF_EN
    logic [15:0] perf_cycles;
`endif

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int cyc    = 0;
    int n_rd, n_wr, n_done, done_at, first_wr, last_wr;

    always #5 clk = ~clk;

    poly_mul_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .busy       (busy),
        .done       (done),
        .sel        (sel),
        .ntt_l      (ntt_l),
        .tf_address (tf_address),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_stage   (rd_stage),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_stage   (wr_stage)
`ifdef POLY_MUL_CTRL_PERF_EN
        ,
        .perf_cycles(perf_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic launch(input logic [2:0] m);
        mode  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = 3'b000;
        cyc   = 1;
    endtask

    task automatic clear_counts;
        n_rd = 0; n_wr = 0; n_done = 0; done_at = 0; first_wr = 0; last_wr = 0;
    endtask

    task automatic tally;
        if (rd_en) n_rd++;
        if (wr_en) begin
            n_wr++;
            if (first_wr == 0) first_wr = cyc;
            last_wr = cyc;
        end
        if (done) begin
            n_done++;
            done_at = cyc;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_sel"}, sel, 0);
        chk({tag, "_ntt_l"}, ntt_l, 0);
        chk({tag, "_tf"}, tf_address, 0);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_rd_stage"}, rd_stage, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_stage"}, wr_stage, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 3'b000;
        #2;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick;
        chk_all_zero("idle");

        // NTT, with an ignored MULT start pulse in the middle
        launch(3'b001);
        clear_counts();
        while (cyc <= 300) begin
            tally();
            if (cyc == 1) begin
                chk("ntt_busy", busy, 1); chk("ntt_sel", sel, 3'b001);
                chk("ntt_rd_en", rd_en, 1); chk("ntt_rd_addr", rd_addr, 0);
            end
            if (cyc >= 1 && cyc <= 32) begin
                chk("ntt_s0_tf", tf_address, 0); chk("ntt_s0_ntt_l", ntt_l, 0);
            end
            if (cyc >= 33 && cyc <= 37) chk("ntt_drain_rd_en", rd_en, 0);
            if (cyc == 38) begin
                chk("ntt_s1_rd_en", rd_en, 1); chk("ntt_s1_stage", rd_stage, 1);
                chk("ntt_s1_addr", rd_addr, 0);
            end
            if (cyc >= 112 && cyc <= 143) begin
                chk("ntt_s3_stage", rd_stage, 3); chk("ntt_s3_addr", rd_addr, cyc - 112);
                chk("ntt_s3_tf", tf_address, 7 + (cyc - 112) / 4);
            end
            if (cyc >= 223 && cyc <= 254) begin
                chk("ntt_s6_stage", rd_stage, 6); chk("ntt_s6_ntt_l", ntt_l, 1);
                chk("ntt_s6_tf", tf_address, 63 + (cyc - 223));
            end
            if (cyc >= 260 && cyc <= 291) begin
                chk("ntt_s7_stage", rd_stage, 7); chk("ntt_s7_ntt_l", ntt_l, 2);
            end
            if (cyc == 5) chk("ntt_wr_pre", wr_en, 0);
            if (cyc == 6) begin
                chk("ntt_wr_first", wr_en, 1); chk("ntt_wr_addr0", wr_addr, 0);
                chk("ntt_wr_stage0", wr_stage, 0);
            end
            if (cyc == 296) begin
                chk("ntt_wr_last_addr", wr_addr, 31); chk("ntt_wr_last_stage", wr_stage, 7);
            end
            if (cyc == 100) begin start = 1'b1; mode = 3'b010; end
            if (cyc == 101) begin start = 1'b0; mode = 3'b000; end
            if (cyc == 150) chk("ntt_sel_kept", sel, 3'b001);
            if (cyc == 297) chk("ntt_busy_done", busy, 1);
            if (cyc == 298) begin chk("ntt_busy_after", busy, 0); chk("ntt_sel_after", sel, 0); end
            tick;
        end
        chk("ntt_rd_count", n_rd, 256); chk("ntt_wr_count", n_wr, 256);
        chk("ntt_done_count", n_done, 1); chk("ntt_done_cycle", done_at, 297);
        chk("ntt_first_wr", first_wr, 6); chk("ntt_last_wr", last_wr, 296);

        // Illegal mode in IDLE
        mode = 3'b011; start = 1'b1;
        tick;
        start = 1'b0; mode = 3'b000;
        chk("illegal_busy", busy, 0); chk("illegal_sel", sel, 0); chk("illegal_rd_en", rd_en, 0);
        tick;
        chk("illegal_busy2", busy, 0);

        // MULT
        launch(3'b010);
        clear_counts();
        while (cyc <= 70) begin
            tally();
            chk("mul_rd_en", rd_en, (cyc <= 64) ? 1 : 0);
            if (cyc <= 64) chk("mul_rd_addr", rd_addr, cyc - 1);
            chk("mul_wr_en", wr_en, (cyc >= 4 && cyc <= 67) ? 1 : 0);
            if (cyc >= 4 && cyc <= 67) chk("mul_wr_addr", wr_addr, cyc - 4);
            chk("mul_done", done, (cyc == 68) ? 1 : 0);
            if (cyc <= 68) begin
                chk("mul_sel", sel, 3'b010); chk("mul_tf", tf_address, 0);
                chk("mul_ntt_l", ntt_l, 2); chk("mul_stage", rd_stage, 0);
            end
`ifdef POLY_MUL_CTRL_PERF_EN
            if (cyc == 68 || cyc == 70) chk("mul_perf", perf_cycles, 68);
`endif
            tick;
        end
        chk("mul_done_cycle", done_at, 68);

        // INTT
        launch(3'b100);
        clear_counts();
        while (cyc <= 308) begin
            tally();
            if (cyc == 1) begin
                chk("intt_stage7", rd_stage, 7); chk("intt_ntt_l", ntt_l, 2);
                chk("intt_tf_first", tf_address, 63); chk("intt_sel", sel, 3'b100);
            end
            if (cyc == 32) chk("intt_tf_last", tf_address, 94);
            if (cyc <= 304 && (cyc - 1) % 38 == 0) begin
                chk("intt_stage_seq", rd_stage, 7 - (cyc - 1) / 38);
                chk("intt_stage_rd_en", rd_en, 1);
            end
            tick;
        end
        chk("intt_rd_count", n_rd, 256); chk("intt_wr_count", n_wr, 256);
        chk("intt_done_count", n_done, 1); chk("intt_done_cycle", done_at, 305);
        chk("intt_first_wr", first_wr, 7); chk("intt_last_wr", last_wr, 304);

        // Async reset in NTT stage 4, then ADD
        launch(3'b001);
        while (cyc < 154) tick;
        chk("rst_pre_stage", rd_stage, 4);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_counts();
        repeat (10) begin
            tally();
            tick;
        end
        chk("midrst_no_done", n_done, 0);
        chk("midrst_idle", busy, 0);

        launch(3'b110);
        clear_counts();
        while (cyc <= 70) begin
            tally();
            if (cyc == 1) begin chk("add_sel", sel, 3'b110); chk("add_ntt_l", ntt_l, 2); end
            tick;
        end
        chk("add_rd_count", n_rd, 64); chk("add_wr_count", n_wr, 64);
        chk("add_done_cycle", done_at, 68); chk("add_last_wr", last_wr, 67);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
